// File: rtl/jump_ras_unit.sv
// jump_ras_unit: jump target computation plus a circular return-address stack (RAS).
//
// Computes JAL/JALR targets and the link address (PC+4) combinationally. It pushes,
// pops or replaces RAS entries from the link-register hints on rd/rs1 (x1 or x5).
// Each pop or replace raises a one-cycle registered pulse when the stack's prediction
// disagrees with the computed target.
//
// Optional feature: define JUMP_MISALIGN_CHK_EN to flag targets with bit 1 set on
// o_misalign. When the macro is undefined, o_misalign is tied low.
//
// Parameters:
//   N      datapath/address width
//   DEPTH  RAS entries (power of 2, >= 2)
// Ports:
//   i_clk, i_rst                 clock, asynchronous active-high reset
//   i_valid, i_jal, i_jalr       jump present and its type (both high treated as JAL)
//   i_pc, i_rs1_data, i_immediate operands for target computation
//   i_rd, i_rs1                  register indices used as link hints
//   i_flush                      empty the stack at the next edge
//   o_jump_target, o_return_addr computed target and PC+4
//   o_ras_top, o_ras_valid       predicted return address and stack non-empty
//   o_ras_count                  stack occupancy
//   o_mispredict                 registered pop-prediction miss
//   o_misalign                   target bit 1 set (only with JUMP_MISALIGN_CHK_EN)
module jump_ras_unit #(
  parameter int unsigned N     = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_valid,
  input  logic                     i_jal,
  input  logic                     i_jalr,
  input  logic [N-1:0]             i_pc,
  input  logic [N-1:0]             i_rs1_data,
  input  logic [N-1:0]             i_immediate,
  input  logic [4:0]               i_rd,
  input  logic [4:0]               i_rs1,
  input  logic                     i_flush,
  output logic [N-1:0]             o_jump_target,
  output logic [N-1:0]             o_return_addr,
  output logic [N-1:0]             o_ras_top,
  output logic                     o_ras_valid,
  output logic [$clog2(DEPTH):0]   o_ras_count,
  output logic                     o_mispredict,
  output logic                     o_misalign
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {ActNone, ActPush, ActPop, ActReplace} act_e;

  logic [N-1:0]  entries_q [DEPTH];
  logic [PW-1:0] ptr_q, ptr_d;     // next slot to write; top lives at ptr_q - 1
  logic [CW-1:0] count_q, count_d;
  logic          mispredict_q, mispredict_d;
  logic [PW-1:0] top_idx;
  logic          rd_link, rs1_link;
  act_e          act;
  logic          we;
  logic [PW-1:0] waddr;

  assign o_return_addr = i_pc + N'(4);

  always_comb begin
    if (i_jal) begin
      o_jump_target = i_pc + i_immediate;
    end else if (i_jalr) begin
      o_jump_target = (i_rs1_data + i_immediate) & ~N'(1);
    end else begin
      o_jump_target = o_return_addr;
    end
  end

`ifdef JUMP_MISALIGN_CHK_EN
  assign o_misalign = i_valid & (i_jal | i_jalr) & o_jump_target[1];
`else
  assign o_misalign = 1'b0;
`endif

  assign rd_link  = (i_rd == 5'd1) || (i_rd == 5'd5);
  assign rs1_link = (i_rs1 == 5'd1) || (i_rs1 == 5'd5);

  always_comb begin
    act = ActNone;
    if (i_valid) begin
      if (i_jal) begin
        if (rd_link) act = ActPush;
      end else if (i_jalr) begin
        unique case ({rd_link, rs1_link})
          2'b10:   act = ActPush;
          2'b01:   act = ActPop;
          2'b11:   act = (i_rd == i_rs1) ? ActPush : ActReplace;
          default: act = ActNone;
        endcase
      end
    end
  end

  assign top_idx     = ptr_q - PW'(1);
  assign o_ras_top   = entries_q[top_idx];
  assign o_ras_valid = (count_q != '0);
  assign o_ras_count = count_q;
  assign o_mispredict = mispredict_q;

  always_comb begin
    ptr_d        = ptr_q;
    count_d      = count_q;
    we           = 1'b0;
    waddr        = ptr_q;
    mispredict_d = 1'b0;
    if (i_flush) begin
      count_d = '0;
    end else begin
      if (act == ActPop || act == ActReplace) begin
        mispredict_d = !o_ras_valid || (o_ras_top != o_jump_target);
      end
      // Replace on an empty stack behaves as a plain push.
      if (act == ActPush || (act == ActReplace && !o_ras_valid)) begin
        we    = 1'b1;
        waddr = ptr_q;
        ptr_d = ptr_q + PW'(1);
        if (count_q != CW'(DEPTH)) count_d = count_q + CW'(1);
      end else if (act == ActReplace) begin
        we    = 1'b1;
        waddr = top_idx;
      end else if (act == ActPop && o_ras_valid) begin
        ptr_d   = top_idx;
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ptr_q        <= '0;
      count_q      <= '0;
      mispredict_q <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      count_q      <= count_d;
      mispredict_q <= mispredict_d;
    end
  end

  // Entry storage is not reset; count gates its visibility.
  always_ff @(posedge i_clk) begin
    if (we) entries_q[waddr] <= o_return_addr;
  end

endmodule

// File: tb/tb_jump_ras_unit.sv
module tb_jump_ras_unit;

  localparam int unsigned N     = 32;
  localparam int unsigned DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid, jal, jalr, flush;
  logic [N-1:0]  pc, rs1_data, imm;
  logic [4:0]    rd, rs1;
  logic [N-1:0]  jump_target, return_addr, ras_top;
  logic          ras_valid, mispredict, misalign;
  logic [3:0]    ras_count;

  int passed = 0;
  int total  = 0;

  // Reference stack: most recent entry at the back.
  logic [N-1:0] model_q[$];

  jump_ras_unit #(.N(N), .DEPTH(DEPTH)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_valid       (valid),
    .i_jal         (jal),
    .i_jalr        (jalr),
    .i_pc          (pc),
    .i_rs1_data    (rs1_data),
    .i_immediate   (imm),
    .i_rd          (rd),
    .i_rs1         (rs1),
    .i_flush       (flush),
    .o_jump_target (jump_target),
    .o_return_addr (return_addr),
    .o_ras_top     (ras_top),
    .o_ras_valid   (ras_valid),
    .o_ras_count   (ras_count),
    .o_mispredict  (mispredict),
    .o_misalign    (misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit is_link(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

  // Drive one cycle of stimulus, check combinational outputs, then the state after the edge.
  task automatic jump(input logic v, input logic j, input logic jr, input logic [4:0] d,
                      input logic [4:0] s, input logic [N-1:0] p, input logic [N-1:0] r1,
                      input logic [N-1:0] im, input logic fl);
    logic [N-1:0] tgt;
    logic         exp_mis, exp_misp;
    bit           do_push, do_pop;
    valid = v; jal = j; jalr = jr; rd = d; rs1 = s; pc = p; rs1_data = r1; imm = im;
    flush = fl;
    #1;
    if (j)       tgt = p + im;
    else if (jr) tgt = (r1 + im) & 32'hFFFF_FFFE;
    else         tgt = p + 32'd4;
    chk("target", jump_target, tgt);
    chk("return_addr", return_addr, p + 32'd4);
`ifdef JUMP_MISALIGN_CHK_EN
    exp_mis = v & (j | jr) & tgt[1];
`else
    exp_mis = 1'b0;
`endif
    chk("misalign", {31'd0, misalign}, {31'd0, exp_mis});
    do_push = 0;
    do_pop  = 0;
    if (v && j) begin
      do_push = is_link(d);
    end else if (v && jr) begin
      do_push = is_link(d);
      do_pop  = is_link(s) && !(is_link(d) && d == s);
    end
    exp_misp = do_pop && !fl && ((model_q.size() == 0) || (model_q[$] != tgt));
    if (fl) begin
      model_q.delete();
    end else begin
      if (do_pop && model_q.size() > 0) void'(model_q.pop_back());
      if (do_push) begin
        if (model_q.size() == DEPTH) void'(model_q.pop_front());
        model_q.push_back(p + 32'd4);
      end
    end
    @(posedge clk);
    #1;
    chk("count", {28'd0, ras_count}, model_q.size());
    chk("ras_valid", {31'd0, ras_valid}, {31'd0, model_q.size() != 0});
    chk("mispredict", {31'd0, mispredict}, {31'd0, exp_misp});
    if (model_q.size() != 0) chk("ras_top", ras_top, model_q[$]);
  endtask

  task automatic idle();
    jump(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0);
  endtask

  initial begin
    logic [4:0]   rsel [4];
    logic [N-1:0] r1v, imv;
    logic [1:0]   ty;
    rst = 1'b1; valid = 0; jal = 0; jalr = 0; flush = 0;
    pc = '0; rs1_data = '0; imm = '0; rd = '0; rs1 = '0;
    #12;
    chk("rst_count", {28'd0, ras_count}, 32'd0);
    chk("rst_valid", {31'd0, ras_valid}, 32'd0);
    chk("rst_misp", {31'd0, mispredict}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic call then matching return.
    jump(1, 1, 0, 5'd1, 5'd0, 32'h100, 32'h0, 32'h40, 0);
    chk("call_top", ras_top, 32'h104);
    jump(1, 0, 1, 5'd0, 5'd1, 32'h200, 32'h104, 32'h0, 0);
    chk("ret_count", {28'd0, ras_count}, 32'd0);

    // Overflow by one, then drain past empty.
    for (int i = 0; i < 9; i++) jump(1, 1, 0, 5'd1, 5'd0, 32'(i * 16), 32'h0, 32'h0, 0);
    chk("full_count", {28'd0, ras_count}, 32'd8);
    chk("full_top", ras_top, 32'h84);
    for (int i = 0; i < 8; i++) begin
      chk("drain_top", ras_top, 32'h84 - 32'(i * 16));
      jump(1, 0, 1, 5'd0, 5'd1, 32'h1000, 32'h84 - 32'(i * 16), 32'h0, 0);
    end
    jump(1, 0, 1, 5'd0, 5'd1, 32'h1000, 32'h14, 32'h0, 0);
    chk("empty_pop_misp", {31'd0, mispredict}, 32'd1);
    idle();

    // Replace with a wrong prediction.
    jump(1, 1, 0, 5'd1, 5'd0, 32'h1FC, 32'h0, 32'h0, 0);
    jump(1, 0, 1, 5'd5, 5'd1, 32'h40, 32'h300, 32'h0, 0);
    chk("repl_misp", {31'd0, mispredict}, 32'd1);
    chk("repl_top", ras_top, 32'h44);
    idle();

    // Flush dominates a simultaneous push and a would-be miss.
    jump(1, 1, 0, 5'd5, 5'd0, 32'h600, 32'h0, 32'h0, 0);
    jump(1, 1, 0, 5'd1, 5'd0, 32'h700, 32'h0, 32'h0, 0);
    chk("pre_flush_count", {28'd0, ras_count}, 32'd3);
    jump(1, 1, 0, 5'd1, 5'd0, 32'h800, 32'h0, 32'h0, 1);
    jump(1, 1, 0, 5'd1, 5'd0, 32'h900, 32'h0, 32'h0, 0);
    jump(1, 0, 1, 5'd0, 5'd1, 32'h0, 32'hDEAD0, 32'h0, 1);

    // Asynchronous reset in the middle of a push, right after a miss pulse.
    jump(1, 1, 0, 5'd1, 5'd0, 32'hA00, 32'h0, 32'h0, 0);
    jump(1, 0, 1, 5'd0, 5'd1, 32'h0, 32'h55550, 32'h0, 0);
    valid = 1; jal = 1; jalr = 0; rd = 5'd1; pc = 32'hB00; flush = 0;
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_count", {28'd0, ras_count}, 32'd0);
    chk("midrst_misp", {31'd0, mispredict}, 32'd0);
    model_q.delete();
    valid = 0;
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    jump(1, 1, 0, 5'd1, 5'd0, 32'h500, 32'h0, 32'h0, 0);
    chk("post_rst_top", ras_top, 32'h504);

    // Misaligned JAL target.
    jump(1, 1, 0, 5'd0, 5'd0, 32'h100, 32'h0, 32'h2, 0);

    // Randomized traffic against the reference stack.
    rsel[0] = 5'd0; rsel[1] = 5'd1; rsel[2] = 5'd5;
    for (int i = 0; i < 400; i++) begin
      rsel[3] = 5'($urandom);
      ty = 2'($urandom);
      imv = ($urandom_range(0, 1) == 0) ? 32'h0 : ($urandom & 32'h0000_0FFE);
      if (model_q.size() != 0 && $urandom_range(0, 1) == 0) r1v = model_q[$] - imv;
      else r1v = $urandom;
      jump($urandom_range(0, 7) != 0, ty[0], ty[1], rsel[$urandom_range(0, 3)],
           rsel[$urandom_range(0, 3)], $urandom & 32'hFFFF_FFFC, r1v, imv,
           $urandom_range(0, 15) == 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
